// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// The master side is the supervisor: it samples lock/restart and drives the reset/status outputs.
interface pll_lock_supervisor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             restart;
    logic             pll_areset;
    logic             sys_rst_n;
    logic             pll_ok;
    logic             pll_fail;
    logic [3:0]       retry_cnt;
    logic [CNT_W-1:0] lol_count;
    logic [2:0]       state;

    modport master (
        input  pll_locked, restart,
        output pll_areset, sys_rst_n, pll_ok, pll_fail, retry_cnt, lol_count, state
    );

    modport slave (
        output pll_locked, restart,
        input  pll_areset, sys_rst_n, pll_ok, pll_fail, retry_cnt, lol_count, state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses areset, waits for lock with timeout/retries, qualifies lock stability,
// then releases the downstream reset; loss of lock re-arms the PLL and is counted.
module pll_lock_supervisor #(
    parameter int unsigned ARESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_lock_supervisor_if.master bus
);

    localparam int unsigned TMAX_A = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int unsigned TW     = (TMAX <= 2) ? 1 : $clog2(TMAX);

    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nxt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_nxt;
    logic [CNT_W-1:0] r_lol;
    logic [CNT_W-1:0] w_lol_nxt;
    logic             r_pll_areset;
    logic             r_sys_rst_n;
    logic             r_pll_ok;
    logic             r_pll_fail;
    logic [2:0]       r_state_dbg;
    logic             w_locked_s;
    logic             w_areset_done;
    logic             w_lock_timeout;
    logic             w_stable_done;

    assign w_locked_s     = r_sync2;
    assign w_areset_done  = (r_timer == TW'(ARESET_CYCLES - 1));
    assign w_lock_timeout = (r_timer == TW'(LOCK_TIMEOUT - 1));
    assign w_stable_done  = (r_timer == TW'(STABLE_CYCLES - 1));

    // pll_locked comes from the PLL's own clock domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RST_PLL;
            r_timer <= '0;
            r_retry <= '0;
            r_lol   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_retry <= w_retry_nxt;
            r_lol   <= w_lol_nxt;
        end
    end

    // restart beats every other transition, including a loss of lock in RUN
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_lol_nxt   = r_lol;
        if (bus.restart) begin
            w_state_nxt = ST_RST_PLL;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_RST_PLL: begin
                    if (w_areset_done) w_state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (w_lock_timeout) begin
                        if (r_retry == 4'(MAX_RETRIES)) begin
                            w_state_nxt = ST_FAIL;
                        end else begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = ST_RST_PLL;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (w_stable_done) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_RST_PLL;
                        if (r_lol != {CNT_W{1'b1}}) w_lol_nxt = r_lol + CNT_W'(1);
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_RST_PLL;
                end
            endcase
        end
        w_timer_nxt = (bus.restart || (w_state_nxt != r_state)) ? '0 : r_timer + TW'(1);
    end

    // Moore output decode, one register stage behind the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pll_areset <= 1'b1;
            r_sys_rst_n  <= 1'b0;
            r_pll_ok     <= 1'b0;
            r_pll_fail   <= 1'b0;
            r_state_dbg  <= 3'(ST_RST_PLL);
        end else begin
            r_pll_areset <= (r_state == ST_RST_PLL) || (r_state == ST_FAIL);
            r_sys_rst_n  <= (r_state == ST_RUN);
            r_pll_ok     <= (r_state == ST_RUN);
            r_pll_fail   <= (r_state == ST_FAIL);
            r_state_dbg  <= r_state;
        end
    end

    assign bus.pll_areset = r_pll_areset;
    assign bus.sys_rst_n  = r_sys_rst_n;
    assign bus.pll_ok     = r_pll_ok;
    assign bus.pll_fail   = r_pll_fail;
    assign bus.retry_cnt  = r_retry;
    assign bus.lol_count  = r_lol;
    assign bus.state      = r_state_dbg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a driver pushes model predictions per clock edge,
// a monitor pops and compares them against the DUT outputs.
module tb_pll_lock_supervisor;

    localparam int unsigned AR = 4;
    localparam int unsigned LT = 32;
    localparam int unsigned SC = 8;
    localparam int unsigned MR = 2;
    localparam int unsigned CW = 2;
    localparam int          LOL_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          areset;
        logic          srst;
        logic          ok;
        logic          fail;
        logic [3:0]    retry;
        logic [CW-1:0] lol;
        logic [2:0]    st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pll_lock_supervisor_if #(.CNT_W(CW)) bus();

    pll_lock_supervisor #(
        .ARESET_CYCLES(AR),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR),
        .CNT_W        (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   rise_edge = -1;
    int   fall_edge = -1;

    // reference model: phase 0..4 named as in the debug encoding, age = cycles spent in phase
    int   m_ph, m_age, m_retry, m_lol;
    logic m_s1, m_s2;

    task automatic model_edge(input logic rn, input logic lk, input logic rq, output exp_t e);
        int   old_ph, nxt;
        logic ls;
        if (!rn) begin
            m_ph = 0; m_age = 0; m_retry = 0; m_lol = 0; m_s1 = 1'b0; m_s2 = 1'b0;
            e = '0;
            e.areset = 1'b1;
            return;
        end
        old_ph = m_ph;
        ls     = m_s2;
        m_s2   = m_s1;
        m_s1   = lk;
        nxt    = old_ph;
        if (rq) begin
            nxt = 0;
            m_retry = 0;
        end else begin
            case (old_ph)
                0: if (m_age + 1 >= int'(AR)) nxt = 1;
                1: begin
                    if (ls) nxt = 2;
                    else if (m_age + 1 >= int'(LT)) begin
                        if (m_retry >= int'(MR)) nxt = 4;
                        else begin m_retry++; nxt = 0; end
                    end
                end
                2: begin
                    if (!ls) nxt = 1;
                    else if (m_age + 1 >= int'(SC)) begin nxt = 3; m_retry = 0; end
                end
                3: if (!ls) begin
                    nxt = 0;
                    m_lol = (m_lol < LOL_MAX) ? m_lol + 1 : LOL_MAX;
                end
                default: nxt = old_ph;
            endcase
        end
        m_age = (rq || nxt != old_ph) ? 0 : m_age + 1;
        m_ph  = nxt;
        e.areset = (old_ph == 0) || (old_ph == 4);
        e.srst   = (old_ph == 3);
        e.ok     = (old_ph == 3);
        e.fail   = (old_ph == 4);
        e.retry  = 4'(m_retry);
        e.lol    = CW'(m_lol);
        e.st     = 3'(old_ph);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // drive one edge's worth of inputs, predict the outputs after that edge
    task automatic step(input logic rn, input logic lk, input logic rq);
        exp_t e;
        rst_n          = rn;
        bus.pll_locked = lk;
        bus.restart    = rq;
        model_edge(rn, lk, rq, e);
        q.push_back(e);
        n_push++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic lk);
        for (int i = 0; i < n; i++) step(1'b1, lk, 1'b0);
    endtask

    exp_t mon_e, mon_a;
    logic mon_prev = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                n_pop++;
                mon_a.areset = bus.pll_areset;
                mon_a.srst   = bus.sys_rst_n;
                mon_a.ok     = bus.pll_ok;
                mon_a.fail   = bus.pll_fail;
                mon_a.retry  = bus.retry_cnt;
                mon_a.lol    = bus.lol_count;
                mon_a.st     = bus.state;
                n_chk++;
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL scoreboard edge %0d: got areset=%b srst=%b ok=%b fail=%b retry=%0d lol=%0d st=%0d, expected areset=%b srst=%b ok=%b fail=%b retry=%0d lol=%0d st=%0d",
                             n_pop, mon_a.areset, mon_a.srst, mon_a.ok, mon_a.fail, mon_a.retry, mon_a.lol, mon_a.st,
                             mon_e.areset, mon_e.srst, mon_e.ok, mon_e.fail, mon_e.retry, mon_e.lol, mon_e.st);
                end
                if (!mon_prev && bus.sys_rst_n === 1'b1) rise_edge = n_pop;
                if (mon_prev && bus.sys_rst_n === 1'b0) fall_edge = n_pop;
                mon_prev = (bus.sys_rst_n === 1'b1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int lock_edge, d, seg_p;
        int lol_exp[5] = '{1, 2, 3, 3, 3};
        logic lk, rq, rn;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("reset_areset", int'(bus.pll_areset), 1);
        check("reset_sys_rst_n", int'(bus.sys_rst_n), 0);

        // first lock after release
        run(9, 1'b0);
        lock_edge = n_push + 1;
        run(15, 1'b1);
        check("lock_to_run_latency", rise_edge - lock_edge, int'(SC) + 3);
        check("run_retry_cnt", int'(bus.retry_cnt), 0);

        // restart from RUN, then a lock glitch while qualifying
        step(1'b1, 1'b1, 1'b1);
        run(6, 1'b1);
        run(3, 1'b0);
        lock_edge = n_push + 1;
        run(20, 1'b1);
        check("relock_latency", rise_edge - lock_edge, int'(SC) + 3);
        check("restart_no_lol", int'(bus.lol_count), 0);

        // repeated loss of lock, counter saturates
        for (int j = 0; j < 5; j++) begin
            d = n_push + 1;
            run(3, 1'b0);
            run(20, 1'b1);
            if (j == 0) check("loss_latency", fall_edge - d, 3);
            check($sformatf("lol_count_%0d", j), int'(bus.lol_count), lol_exp[j]);
        end

        // no lock at all: retries exhaust into FAIL
        run(3 * int'(AR + LT) + 12, 1'b0);
        check("fail_pll_fail", int'(bus.pll_fail), 1);
        check("fail_areset", int'(bus.pll_areset), 1);
        check("fail_retry_cnt", int'(bus.retry_cnt), int'(MR));
        check("fail_sys_rst_n", int'(bus.sys_rst_n), 0);

        // restart out of FAIL, reach RUN, then a one-edge reset
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("restart_pll_fail", int'(bus.pll_fail), 0);
        check("restart_retry_cnt", int'(bus.retry_cnt), 0);
        run(30, 1'b1);
        check("rerun_sys_rst_n", int'(bus.sys_rst_n), 1);
        step(1'b0, 1'b1, 1'b0);
        check("midrst_areset", int'(bus.pll_areset), 1);
        check("midrst_sys_rst_n", int'(bus.sys_rst_n), 0);
        check("midrst_ok", int'(bus.pll_ok), 0);
        check("midrst_lol", int'(bus.lol_count), 0);
        check("midrst_state", int'(bus.state), 0);

        // randomized lock behaviour with occasional restarts and resets
        lk = 1'b1;
        seg_p = 20;
        for (int i = 0; i < 2400; i++) begin
            if (i % 200 == 0) seg_p = int'($urandom_range(4, 60));
            if ($urandom_range(0, seg_p - 1) == 0) lk = ~lk;
            rq = ($urandom_range(0, 79) == 0);
            rn = ($urandom_range(0, 399) != 0);
            step(rn, lk, rq);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
